// File: rtl/ram_param_if.sv
// ram_param_if: access bus between a memory client and ram_param.
//   master -> drives load/address/data_in/rd_en/clear, observes ram_out/rd_valid/busy
//   slave  -> the RAM side of the same signals
// Ports (bus signals):
//   load     write enable
//   address  word address, ADDR_W bits
//   data_in  write data, WIDTH bits
//   rd_en    read request
//   clear    request a full clear sweep
//   ram_out  registered read data
//   rd_valid one-cycle strobe marking fresh ram_out
//   busy     clear sweep in progress, accesses are ignored
interface ram_param_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) ();

  logic              load;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  data_in;
  logic              rd_en;
  logic              clear;
  logic [WIDTH-1:0]  ram_out;
  logic              rd_valid;
  logic              busy;

  modport master (
    output load, address, data_in, rd_en, clear,
    input  ram_out, rd_valid, busy
  );

  modport slave (
    input  load, address, data_in, rd_en, clear,
    output ram_out, rd_valid, busy
  );

endinterface

// File: rtl/ram_param.sv
// ram_param: parametrised single-port RAM with registered read, valid strobe,
// selectable read-during-write behaviour and a clear sequencer that sweeps
// every word to CLEAR_VALUE after reset or on request.
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  asynchronous, active-high reset; starts a fresh clear sweep
//   bus    ram_param_if.slave: load/address/data_in/rd_en/clear in,
//          ram_out/rd_valid/busy out (all outputs registered)
// Parameters:
//   WIDTH       data word width
//   ADDR_W      address width, DEPTH = 2**ADDR_W
//   WRITE_MODE  same-cycle load+rd_en: 0 returns old data, 1 returns data_in
//   CLEAR_VALUE value written to every word by the sweep
module ram_param #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      ADDR_W      = 3,
  parameter int unsigned      WRITE_MODE  = 0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  ram_param_if.slave   bus
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam bit                WR_FIRST = (WRITE_MODE != 0);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]        state,     state_nxt;
  logic [ADDR_W-1:0] ptr,       ptr_nxt;
  logic [WIDTH-1:0]  ram_out_q, ram_out_nxt;
  logic              rd_valid_q, rd_valid_nxt;
  logic              busy_q,    busy_nxt;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [WIDTH-1:0]  mem_wdata_c;
  logic [WIDTH-1:0]  rd_data_c;

  logic [WIDTH-1:0]  mem [DEPTH];

  // Read-data source: stored word, or the bypassed write data in write-first mode
  always_comb begin
    rd_data_c = mem[bus.address];
    if (WR_FIRST && bus.load) begin
      rd_data_c = bus.data_in;
    end
  end

  // Next-state, sweep pointer, memory write port and output next values
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    ram_out_nxt  = ram_out_q;
    rd_valid_nxt = 1'b0;
    mem_we_c     = 1'b0;
    mem_waddr_c  = bus.address;
    mem_wdata_c  = bus.data_in;

    case (state)
      ST_CLEAR: begin
        // One word per cycle; accesses and further clear requests are ignored
        mem_we_c    = 1'b1;
        mem_waddr_c = ptr;
        mem_wdata_c = CLEAR_VALUE;
        ptr_nxt     = ptr + ADDR_W'(1);
        if (ptr == LAST_PTR) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          // Clear wins over any access issued in the same cycle
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end else begin
          if (bus.rd_en) begin
            ram_out_nxt  = rd_data_c;
            rd_valid_nxt = 1'b1;
          end
          if (bus.load) begin
            mem_we_c = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        ptr_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt == ST_CLEAR);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      ptr        <= '0;
      ram_out_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      ram_out_q  <= ram_out_nxt;
      rd_valid_q <= rd_valid_nxt;
      busy_q     <= busy_nxt;
    end
  end

  // Storage array; initialised only by the sweep, never by reset
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign bus.ram_out  = ram_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: three ram_param instances checked cycle by cycle against a
// behavioural model.
//   u0: 16 bit x 8,  read-first,  CLEAR_VALUE 0x0000
//   u1: 16 bit x 8,  write-first, CLEAR_VALUE 0xA5A5
//   u2: 32 bit x 64, read-first,  CLEAR_VALUE 0x0000
// All three see the same stimulus (address/data truncated to their size).
module tb_ram_param;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_param_if #(.WIDTH(16), .ADDR_W(3)) bus0 ();
  ram_param_if #(.WIDTH(16), .ADDR_W(3)) bus1 ();
  ram_param_if #(.WIDTH(32), .ADDR_W(6)) bus2 ();

  ram_param #(.WIDTH(16), .ADDR_W(3), .WRITE_MODE(0), .CLEAR_VALUE(16'h0000))
    u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  ram_param #(.WIDTH(16), .ADDR_W(3), .WRITE_MODE(1), .CLEAR_VALUE(16'hA5A5))
    u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  ram_param #(.WIDTH(32), .ADDR_W(6), .WRITE_MODE(0), .CLEAR_VALUE(32'h0000_0000))
    u2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Per-instance configuration for the model
  int          depth   [N] = '{8, 8, 64};
  bit          wr_first[N] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] clr_val [N] = '{32'h0000_0000, 32'h0000_A5A5, 32'h0000_0000};
  logic [31:0] dmask   [N] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};

  // Model state: contents, remaining sweep words, expected outputs
  logic [31:0] mm        [N][64];
  int          sweep_left[N];
  logic [31:0] exp_out   [N];
  logic        exp_valid [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input logic b, input logic v, input logic [31:0] o);
    chk($sformatf("u%0d.busy", k),     32'(b), 32'(sweep_left[k] > 0));
    chk($sformatf("u%0d.rd_valid", k), 32'(v), 32'(exp_valid[k]));
    chk($sformatf("u%0d.ram_out", k),  o,      exp_out[k]);
  endtask

  task automatic check_all();
    check_dut(0, bus0.busy, bus0.rd_valid, 32'(bus0.ram_out));
    check_dut(1, bus1.busy, bus1.rd_valid, 32'(bus1.ram_out));
    check_dut(2, bus2.busy, bus2.rd_valid, bus2.ram_out);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      sweep_left[k] = depth[k];
      exp_out[k]    = '0;
      exp_valid[k]  = 1'b0;
    end
  endtask

  // One rising edge of every instance, expressed as the memory's rules
  task automatic model_edge(input logic l, input logic [5:0] ad, input logic [31:0] dd,
                            input logic r, input logic c);
    for (int k = 0; k < N; k++) begin
      int          a;
      logic [31:0] d;
      a = int'(ad) % depth[k];
      d = dd & dmask[k];
      if (sweep_left[k] > 0) begin
        mm[k][depth[k] - sweep_left[k]] = clr_val[k];
        sweep_left[k]--;
        exp_valid[k] = 1'b0;
      end else if (c) begin
        sweep_left[k] = depth[k];
        exp_valid[k]  = 1'b0;
      end else begin
        if (r) begin
          exp_out[k]   = (l && wr_first[k]) ? d : mm[k][a];
          exp_valid[k] = 1'b1;
        end else begin
          exp_valid[k] = 1'b0;
        end
        if (l) mm[k][a] = d;
      end
    end
  endtask

  task automatic drive(input logic l, input logic [5:0] ad, input logic [31:0] dd,
                       input logic r, input logic c);
    bus0.load = l; bus0.address = ad[2:0]; bus0.data_in = dd[15:0]; bus0.rd_en = r; bus0.clear = c;
    bus1.load = l; bus1.address = ad[2:0]; bus1.data_in = dd[15:0]; bus1.rd_en = r; bus1.clear = c;
    bus2.load = l; bus2.address = ad;      bus2.data_in = dd;       bus2.rd_en = r; bus2.clear = c;
  endtask

  task automatic step(input logic l, input logic [5:0] ad, input logic [31:0] dd,
                      input logic r, input logic c);
    drive(l, ad, dd, r, c);
    @(posedge clk);
    if (!reset) model_edge(l, ad, dd, r, c);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 64; i++) step(1'b0, 6'(i), 32'd0, 1'b1, 1'b0);
    idle(1);
  endtask

  // Asynchronous reset pulse taken mid-cycle, held across one edge
  task automatic do_reset();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    #1;
    do_reset();

    // Busy lockout: write during the sweep must be dropped
    step(1'b1, 6'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idle(70);
    step(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
    idle(1);

    // Write 1,3,7,F pattern to 0..7, read back 7 down to 0
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pat;
      pat = (32'd1 << ((i % 4) + 1)) - 32'd1;
      step(1'b1, 6'(i), pat, 1'b0, 1'b0);
    end
    for (int i = 7; i >= 0; i--) step(1'b0, 6'(i), 32'd0, 1'b1, 1'b0);
    idle(2);

    // Read-during-write at address 5, then follow-up read
    step(1'b1, 6'd5, 32'h0000_1234, 1'b0, 1'b0);
    step(1'b1, 6'd5, 32'h0000_BEEF, 1'b1, 1'b0);
    step(1'b0, 6'd5, 32'd0, 1'b1, 1'b0);
    idle(1);

    // Full-width data at the lowest and highest address of the wide instance
    step(1'b1, 6'd0,  32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b1, 6'd63, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b0, 6'd0,  32'd0, 1'b1, 1'b0);
    step(1'b0, 6'd63, 32'd0, 1'b1, 1'b0);
    idle(1);

    // Preloaded contents wiped by a reset sweep
    do_reset();
    idle(70);
    read_all();

    // Clear with a simultaneous load and read: both dropped
    step(1'b1, 6'd2, 32'h0000_5555, 1'b1, 1'b1);
    idle(70);
    read_all();

    // Reset four cycles into a requested sweep
    step(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
    idle(4);
    do_reset();
    idle(70);
    read_all();

    // Randomised traffic with occasional clear requests
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
    end
    idle(70);
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_param.md
Name: ram_param

Overview:
- Parametrised single-port RAM; next generation of the 8-word, 16-bit register-file RAM.
- Configurable width and depth, plus:
  - a registered read with a valid strobe;
  - a selectable read-during-write mode;
  - a hardware clear sequencer that sweeps every word to a known value after reset or on request.
- Sits between the CPU datapath (A-register address, D/ALU data) and data/program memory.

Parameters:
- WIDTH, 16: data word width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W words.
- WRITE_MODE, 0: read-during-write to the same address. 0 = read-first (old data), 1 = write-first (new data).
- CLEAR_VALUE, 0: WIDTH-bit value written to every word by the clear sweep.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- load, input, 1: write enable; writes data_in to mem[address] at the clock edge.
- address, input, ADDR_W: word address for read and write.
- data_in, input, WIDTH: write data.
- rd_en, input, 1: read request; sampled at the clock edge.
- clear, input, 1: request a full clear sweep; single-cycle pulse or level.
- ram_out, output, WIDTH: registered read data.
- rd_valid, output, 1: high for exactly one cycle when ram_out carries data for a read accepted on the previous edge.
- busy, output, 1: high while a clear sweep runs; accesses are ignored.

Behaviour:
- Reset (asynchronous, while reset = 1):
  - ram_out = 0, rd_valid = 0, busy = 1.
  - State goes to CLEAR with sweep pointer = 0.
  - Memory array is not reset directly; the sweep initialises it.
- State machine has two states, CLEAR and IDLE.
- CLEAR:
  - Each cycle: mem[ptr] <= CLEAR_VALUE, ptr <= ptr+1.
  - After writing ptr = DEPTH-1, go to IDLE on the next edge.
  - The sweep takes exactly DEPTH cycles after reset deassertion; busy falls on the edge that writes the last word.
- IDLE: busy = 0; accesses are accepted.
- clear = 1 in IDLE:
  - Next edge enters CLEAR with ptr = 0 and busy = 1.
  - A load or rd_en in that same cycle is dropped; clear has priority.
- clear = 1 while already in CLEAR: ignored; the sweep is not restarted.
- reset asserted mid-sweep: asynchronous abort; the sweep restarts at ptr = 0 after release.
- Access while busy:
  - load and rd_en are ignored; no memory write.
  - rd_valid stays 0; ram_out holds its value.
- Write: in IDLE, load = 1 at edge N gives mem[address] = data_in, visible to a read issued at edge N+1 or later.
- Read:
  - In IDLE, rd_en = 1 at edge N gives ram_out = mem[address] and rd_valid = 1 after edge N.
  - Latency is 1 cycle.
  - Back-to-back reads are allowed every cycle.
- ram_out holds the last read data when rd_en = 0. rd_valid returns to 0 on the next edge with no accepted read.
- load and rd_en together, same cycle (always the same address, since single-port):
  - WRITE_MODE = 0: ram_out = old contents.
  - WRITE_MODE = 1: ram_out = data_in.
  - In both modes the write completes.
- address is used in full; no out-of-range addresses exist (DEPTH = 2**ADDR_W).
- Data is exactly WIDTH bits; no truncation or extension.

Test Plan (WIDTH=16, ADDR_W=3 unless stated):
- Reset sweep: preload words via a prior run, pulse reset, then read all 8 addresses. Required: busy high for 8 cycles after release; every read returns 0x0000; each rd_valid lags rd_en by 1 cycle.
- Write/read: write 0x0001, 0x0003, 0x0007, 0x000F, 0x0001, 0x0003, 0x0007, 0x000F to addresses 0–7, then read 7 down to 0. Required: ram_out follows 0x000F, 0x0007, 0x0003, 0x0001, 0x000F, … with rd_valid asserted on 8 consecutive cycles.
- Read-during-write: mem[5] = 0x1234, then load = 1, rd_en = 1, address = 5, data_in = 0xBEEF. Required: ram_out = 0x1234 with WRITE_MODE = 0 and 0xBEEF with WRITE_MODE = 1; a follow-up read of address 5 returns 0xBEEF in both modes.
- Clear priority: with CLEAR_VALUE = 0xA5A5, assert clear, load (addr 2, 0x5555) and rd_en in the same cycle. Required: no rd_valid; busy for 8 cycles; afterwards every address reads 0xA5A5.
- Busy lockout and reset mid-sweep:
  - During the sweep, issue load to addr 0 with 0xFFFF. Required: write ignored; addr 0 reads CLEAR_VALUE afterwards.
  - Assert reset at sweep cycle 4. Required: outputs go to reset values immediately; busy stays high for a full 8 cycles after release.
- Parameter sweep with WIDTH = 32 and ADDR_W = 6: write 0xDEADBEEF to addresses 0 and 63, then read both. Required: exact 32-bit data returned; reset sweep lasts 64 cycles.
